// File: rtl/roman_symbol_sequencer_pkg.sv
// roman_pkg: definitions shared by the Roman-numeral symbol sequencer.
//   - Symbol codes carried on out_sym (3-bit, NULL marks an empty field).
//   - Default sizing of the converter and sequencer.
//   - Sequencer FSM state type.
package roman_pkg;

    localparam int DEF_OUT_WIDTH = 3;   // bits per symbol code
    localparam int DEF_OUT_NUM   = 8;   // symbol fields in a converted numeral
    localparam int DEF_MAX_VAL   = 69;  // largest value the converter handles

    localparam logic [2:0] SYM_NULL = 3'd0;
    localparam logic [2:0] SYM_I    = 3'd1;
    localparam logic [2:0] SYM_V    = 3'd2;
    localparam logic [2:0] SYM_X    = 3'd3;
    localparam logic [2:0] SYM_L    = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/roman_symbol_sequencer_if.sv
// roman_symbol_sequencer_if: value-in / symbol-out stream bundle.
//   in_valid/in_ready/in_data  : binary value handshake (producer -> sequencer)
//   out_valid/out_ready        : symbol handshake (sequencer -> consumer)
//   out_sym/out_last           : symbol code and end-of-numeral flag
//   err                        : one-cycle pulse on a rejected out-of-range value
//   busy                       : numeral in flight
//   out_len                    : numeral length, only when ROMAN_SEQ_LEN_EN is defined
// slave modport is the sequencer side, master the producer/consumer side.
interface roman_symbol_sequencer_if #(
    parameter int BIT_WIDTH = 6,
    parameter int OUT_WIDTH = 3
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_sym;
    logic                 out_last;
    logic                 err;
    logic                 busy;
`ifdef ROMAN_SEQ_LEN_EN
    logic [3:0]           out_len;
`endif

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sym, out_last, err, busy
`ifdef ROMAN_SEQ_LEN_EN
        , output out_len
`endif
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sym, out_last, err, busy
`ifdef ROMAN_SEQ_LEN_EN
        , input out_len
`endif
    );

endinterface

// File: rtl/roman_symbol_sequencer_bin2roman.sv
// bin2roman_base10: combinational binary (0..69) to Roman numeral converter.
//   bin_in    : binary value
//   roman_out : OUT_NUM packed symbol codes, right-aligned; field 0 holds the
//               final symbol, unused leading fields are NULL.
// Values above 69 produce a numeral for the ones digit only; callers reject them.
module bin2roman_base10
    import roman_pkg::*;
#(
    parameter int BIT_WIDTH = 6,
    parameter int OUT_WIDTH = roman_pkg::DEF_OUT_WIDTH,
    parameter int OUT_NUM   = roman_pkg::DEF_OUT_NUM
) (
    input  logic [BIT_WIDTH-1:0]         bin_in,
    output logic [OUT_NUM*OUT_WIDTH-1:0] roman_out
);

    localparam int W = OUT_NUM * OUT_WIDTH;

    // Shift the numeral left by one field and append a symbol at field 0, so
    // emitting symbols in reading order leaves the result right-aligned.
    function automatic logic [W-1:0] app(input logic [W-1:0] r, input logic [2:0] s);
        return (r << OUT_WIDTH) | W'(s);
    endfunction

    int         val;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [W-1:0] res;

    always_comb begin
        val  = 32'(bin_in);
        tens = 4'(val / 10);
        ones = 4'(val % 10);
        res  = '0;
        case (tens)
            4'd1:    res = app(res, SYM_X);
            4'd2:    res = app(app(res, SYM_X), SYM_X);
            4'd3:    res = app(app(app(res, SYM_X), SYM_X), SYM_X);
            4'd4:    res = app(app(res, SYM_X), SYM_L);
            4'd5:    res = app(res, SYM_L);
            4'd6:    res = app(app(res, SYM_L), SYM_X);
            default: res = '0;
        endcase
        case (ones)
            4'd1:    res = app(res, SYM_I);
            4'd2:    res = app(app(res, SYM_I), SYM_I);
            4'd3:    res = app(app(app(res, SYM_I), SYM_I), SYM_I);
            4'd4:    res = app(app(res, SYM_I), SYM_V);
            4'd5:    res = app(res, SYM_V);
            4'd6:    res = app(app(res, SYM_V), SYM_I);
            4'd7:    res = app(app(app(res, SYM_V), SYM_I), SYM_I);
            4'd8:    res = app(app(app(app(res, SYM_V), SYM_I), SYM_I), SYM_I);
            4'd9:    res = app(app(res, SYM_I), SYM_X);
            default: res = res;
        endcase
        roman_out = res;
    end

endmodule

// File: rtl/roman_symbol_sequencer.sv
// roman_symbol_sequencer: accepts a binary value, converts it to a Roman
// numeral and streams it out one symbol per beat, most-significant first.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : roman_symbol_sequencer_if.slave
//                in_valid/in_ready/in_data, out_valid/out_ready/out_sym/out_last,
//                err (reject pulse), busy (numeral in flight)
// Optional macro ROMAN_SEQ_LEN_EN adds bus.out_len: length of the numeral in
// flight, constant across its beats, 0 while idle.
// All outputs are registered; they are computed from the next-state values.
module roman_symbol_sequencer
    import roman_pkg::*;
#(
    parameter int BIT_WIDTH = 6,
    parameter int OUT_WIDTH = roman_pkg::DEF_OUT_WIDTH,
    parameter int OUT_NUM   = roman_pkg::DEF_OUT_NUM,
    parameter int MAX_VAL   = roman_pkg::DEF_MAX_VAL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    roman_symbol_sequencer_if.slave   bus
);

    localparam int SYM_W = OUT_NUM * OUT_WIDTH;
    localparam int IDX_W = $clog2(OUT_NUM);

    logic [SYM_W-1:0]     conv_w;
    logic [3:0]           len_w;
    logic                 accept_w;
    logic                 range_err_w;

    state_t               state_q, state_d;
    logic [SYM_W-1:0]     sym_q, sym_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_sym_q, out_sym_d;
    logic                 out_last_q, out_last_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
`ifdef ROMAN_SEQ_LEN_EN
    logic [3:0]           out_len_q, out_len_d;
`endif

    bin2roman_base10 #(
        .BIT_WIDTH (BIT_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_NUM   (8)
    ) u_conv (
        .bin_in    (bus.in_data),
        .roman_out (conv_w)
    );

    // Length = highest non-NULL field + 1; an all-NULL numeral (value 0)
    // still sends one NULL beat.
    always_comb begin
        len_w = 4'd1;
        for (int i = 0; i < OUT_NUM; i++) begin
            if (conv_w[i*OUT_WIDTH +: OUT_WIDTH] != '0) len_w = 4'(i + 1);
        end
    end

    assign accept_w    = (state_q == IDLE) && bus.in_valid && in_ready_q;
    assign range_err_w = 32'(bus.in_data) > MAX_VAL;

    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_w) begin
                    if (range_err_w) begin
                        err_d = 1'b1;
                    end else begin
                        sym_d   = conv_w;
                        idx_d   = IDX_W'(len_w - 4'd1);
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (out_valid_q && bus.out_ready) begin
                    if (idx_q == '0) state_d = IDLE;
                    else             idx_d   = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d == SEND);
        out_sym_d   = out_valid_d ? sym_d[idx_d*OUT_WIDTH +: OUT_WIDTH] : '0;
        out_last_d  = out_valid_d && (idx_d == '0);
`ifdef ROMAN_SEQ_LEN_EN
        if (!out_valid_d)                  out_len_d = 4'd0;
        else if (accept_w && !range_err_w) out_len_d = len_w;
        else                               out_len_d = out_len_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sym_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ROMAN_SEQ_LEN_EN
            out_len_q   <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            sym_q       <= sym_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
`ifdef ROMAN_SEQ_LEN_EN
            out_len_q   <= out_len_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_last  = out_last_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
`ifdef ROMAN_SEQ_LEN_EN
    assign bus.out_len   = out_len_q;
`endif

endmodule

// File: tb/tb_roman_symbol_sequencer.sv
// Testbench for roman_symbol_sequencer (7-bit input so out-of-range values
// can be presented). Expected symbols come from a greedy Roman-numeral model.
module tb_roman_symbol_sequencer;

    localparam int BW   = 7;
    localparam int MAXV = 69;

    typedef int iq_t[$];

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 0;
    bit   err_exp = 0;
    int   exp_len = 0;
    iq_t  exp_q;

    roman_symbol_sequencer_if #(.BIT_WIDTH(BW), .OUT_WIDTH(3)) bus ();

    roman_symbol_sequencer #(.BIT_WIDTH(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Greedy subtractive Roman numeral; 0 yields a single NULL symbol.
    function automatic iq_t roman_of(input int v);
        iq_t r;
        while (v >= 50) begin r.push_back(4); v -= 50; end
        if (v >= 40) begin r.push_back(3); r.push_back(4); v -= 40; end
        while (v >= 10) begin r.push_back(3); v -= 10; end
        if (v >= 9) begin r.push_back(1); r.push_back(3); v -= 9; end
        if (v >= 5) begin r.push_back(2); v -= 5; end
        if (v >= 4) begin r.push_back(1); r.push_back(2); v -= 4; end
        while (v >= 1) begin r.push_back(1); v -= 1; end
        if (r.size() == 0) r.push_back(0);
        return r;
    endfunction

    function automatic int enc(input iq_t r);
        int c = 0;
        foreach (r[i]) c = c * 16 + r[i];
        return c;
    endfunction

    // Compare process: every falling edge while checking is enabled.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
            chk("busy", int'(bus.busy), int'(exp_q.size() != 0));
            chk("in_ready", int'(bus.in_ready), int'(exp_q.size() == 0));
            chk("err", int'(bus.err), int'(err_exp));
            if (bus.out_valid && exp_q.size() != 0) begin
                chk("out_sym", int'(bus.out_sym), exp_q[0]);
                chk("out_last", int'(bus.out_last), int'(exp_q.size() == 1));
`ifdef ROMAN_SEQ_LEN_EN
                chk("out_len", int'(bus.out_len), exp_len);
`endif
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int v);
        int n = 0;
        iq_t t;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL send_wait: in_ready stuck low, value %0d not sent", v);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = BW'(v);
        @(posedge clk);
        if (v > MAXV) begin
            err_exp = 1'b1;
        end else begin
            t = roman_of(v);
            exp_len = t.size();
            foreach (t[i]) exp_q.push_back(t[i]);
        end
        #1 bus.in_valid = 1'b0;
        bus.in_data = BW'($urandom_range(0, 127));
        if (err_exp) begin
            @(posedge clk); #1 err_exp = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL wait_idle: numeral not drained, %0d symbols left", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Pin the model with hand-computed numerals (hex digit per symbol).
        chk("model_38", enc(roman_of(38)), 'h3332111);
        chk("model_38_len", roman_of(38).size(), 7);
        chk("model_49", enc(roman_of(49)), 'h3413);
        chk("model_69", enc(roman_of(69)), 'h4313);
        chk("model_4", enc(roman_of(4)), 'h12);
        chk("model_0_len", roman_of(0).size(), 1);

        // Reset state
        #12;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_sym", int'(bus.out_sym), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_busy", int'(bus.busy), 0);
`ifdef ROMAN_SEQ_LEN_EN
        chk("rst_out_len", int'(bus.out_len), 0);
`endif
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle_in_ready", int'(bus.in_ready), 1);
        chk_en = 1;

        // Basic numerals at full out_ready
        send(4);  wait_idle();
        send(38); wait_idle();
        send(0);  wait_idle();
        send(10); wait_idle();
        send(27); wait_idle();
        send(44); wait_idle();

        // Backpressure: out_ready low for 3 cycles on the second beat of XLIX
        send(49);
        @(posedge clk); #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_idle();

        // Out-of-range value rejected, then the maximum value
        send(70); wait_idle();
        send(127); wait_idle();
        send(69); wait_idle();

        // Reset during the third beat of 38, then a fresh numeral
        send(38);
        @(posedge clk); @(posedge clk);
        #2 chk_en = 0; rst_n = 1'b0;
        exp_q.delete();
        #1 chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_in_ready", int'(bus.in_ready), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); @(posedge clk);
        #1 chk("post_rst_in_ready", int'(bus.in_ready), 1);
        chk("post_rst_out_valid", int'(bus.out_valid), 0);
        chk_en = 1;
        send(2); wait_idle();
        send(1); wait_idle();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
